uart_receiver: RTL and testbench

UART_RECEIVER -- requirements
Module: uart_receiver

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_receiver_baud_counter.sv | 17 +
 rtl/uart_receiver.sv | 87 ++++++++
 tb/tb_uart_receiver.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and default frame constants shared by the UART receiver and transmitter.
package uart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_BITS_DEF = 8;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_e;
endpackage

// File: rtl/uart_receiver_baud_counter.sv
// BaudCounter: enable-driven oversampling tick counter with synchronous clear.
module BaudCounter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else if (clr_i) cnt_q <= '0;
    else if (en_i) cnt_q <= cnt_q + 1'b1;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with mid-bit sampling, framing-error and break handling.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int DATA_BITS  = DATA_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST = BW'(DATA_BITS - 1);
  uart_state_e          state_q;
  logic [1:0]           sync_q;
  logic                 prev_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q;
  logic                 frame_err_q;
  logic [CW-1:0]        cnt;
  logic                 rx_s;
  logic                 mid;
  logic                 clr;
  assign rx_s = sync_q[1];
  assign mid  = (state_q == START) ? (cnt == HALF) : (cnt == FULL);
  assign clr  = baud_tick && (state_q == IDLE || mid);
  BaudCounter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .en_i  (baud_tick),
    .clr_i (clr),
    .cnt_o (cnt)
  );
  // prev_q follows every tick, so a low stop sample also blocks start detection until rx_s is seen high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= 2'b11;
      prev_q      <= 1'b1;
      state_q     <= IDLE;
      bit_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], rx};
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      if (baud_tick) begin
        prev_q <= rx_s;
        case (state_q)
          IDLE:  if (prev_q && !rx_s) state_q <= START;
          START: if (mid) begin
            state_q <= rx_s ? IDLE : DATA;
            bit_q   <= '0;
          end
          DATA:  if (mid) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == LAST) state_q <= STOP;
          end
          STOP:  if (mid) begin
            state_q     <= IDLE;
            valid_q     <= rx_s;
            frame_err_q <= !rx_s;
            if (rx_s) data_q <= shift_q;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed and randomized frames checked against a byte-level reference model.
module tb_uart_receiver;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
  int checks = 0;
  int errors = 0;
  int vcnt = 0;
  int fcnt = 0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  logic [7:0] last_good;
  uart_receiver dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );
  always #5 clk = ~clk;
  // one baud_tick every 4 clocks: a nominal bit lasts 64 clocks
  initial forever begin
    repeat (3) @(negedge clk);
    baud_tick = 1'b1;
    @(negedge clk);
    baud_tick = 1'b0;
  end
  always @(negedge clk) begin
    if (!rst && valid) begin
      vcnt++;
      got.push_back(data);
    end
    if (!rst && frame_err) fcnt++;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // frame with sender bit period per clocks; rx is left at the stop level afterwards
  task automatic send(input logic [7:0] b, input logic stop, input int per);
    rx = 1'b0;
    repeat (per) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (per) @(negedge clk);
    end
    rx = stop;
    repeat (per) @(negedge clk);
  endtask
  initial begin
    int v0, f0, gi, per, gap;
    logic [7:0] b;
    repeat (4) @(negedge clk);
    check("reset data", data, 0);
    check("reset valid", valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset busy", busy, 0);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (128) @(negedge clk);
    send(8'h55, 1'b1, 64);
    repeat (64) @(negedge clk);
    check("55 valid count", vcnt, 1);
    check("55 frame_err count", fcnt, 0);
    check("55 data", data, 8'h55);
    check("55 busy after", busy, 0);
    last_good = 8'h55;
    send(8'hA3, 1'b1, 64);
    send(8'h0F, 1'b1, 64);
    repeat (64) @(negedge clk);
    check("b2b valid count", vcnt, 3);
    check("b2b first", got[1], 8'hA3);
    check("b2b second", got[2], 8'h0F);
    check("b2b data", data, 8'h0F);
    last_good = 8'h0F;
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (12) @(negedge clk);
    check("glitch busy during start", busy, 1);
    repeat (52) @(negedge clk);
    check("glitch busy after", busy, 0);
    check("glitch valid count", vcnt, 3);
    check("glitch frame_err count", fcnt, 0);
    check("glitch data held", data, last_good);
    send(8'hC4, 1'b0, 64);
    repeat (128) @(negedge clk);
    check("ferr frame_err count", fcnt, 1);
    check("ferr valid count", vcnt, 3);
    check("ferr data held", data, last_good);
    check("break no start", busy, 0);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    send(8'h3C, 1'b1, 64);
    repeat (64) @(negedge clk);
    check("after break valid count", vcnt, 4);
    check("after break data", data, 8'h3C);
    send(8'hF0, 1'b1, 62);
    repeat (64) @(negedge clk);
    check("fast F0 valid count", vcnt, 5);
    check("fast F0 data", data, 8'hF0);
    send(8'hF0 ^ 8'hFF, 1'b1, 64);
    send(8'hF0, 1'b1, 66);
    repeat (64) @(negedge clk);
    check("slow F0 valid count", vcnt, 7);
    check("slow F0 data", data, 8'hF0);
    check("offset frame_err count", fcnt, 1);
    gi = got.size();
    v0 = vcnt;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom);
      per = 62 + 2 * $urandom_range(0, 2);
      gap = $urandom_range(0, 2) * 32;
      send(b, 1'b1, per);
      exp_q.push_back(b);
      repeat (gap) @(negedge clk);
    end
    repeat (64) @(negedge clk);
    check("random valid count", vcnt, v0 + 8);
    for (int k = 0; k < 8; k++) check("random byte", (gi + k < got.size()) ? got[gi + k] : 8'hxx, exp_q[k]);
    check("random frame_err count", fcnt, 1);
    last_good = exp_q[7];
    check("random data", data, last_good);
    v0 = vcnt;
    f0 = fcnt;
    fork
      send(8'h81, 1'b1, 64);
      begin
        repeat (352) @(negedge clk);
        #2;
        check("busy in bit 4", busy, 1);
        rst = 1'b1;
        #1;
        check("async rst data", data, 0);
        check("async rst valid", valid, 0);
        check("async rst frame_err", frame_err, 0);
        check("async rst busy", busy, 0);
      end
    join
    repeat (8) @(negedge clk);
    rst = 1'b0;
    repeat (128) @(negedge clk);
    check("interrupted valid count", vcnt, v0);
    check("interrupted frame_err count", fcnt, f0);
    send(8'h81, 1'b1, 64);
    repeat (64) @(negedge clk);
    check("clean 81 valid count", vcnt, v0 + 1);
    check("clean 81 data", data, 8'h81);
    check("clean 81 busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
